// File: rtl/pong_pkg.sv
// Shared constants and types for the pong board: key count, 50 MHz derived
// debounce/auto-repeat defaults and the packed key vector type.
package pong_pkg;

    localparam int KEYS_W              = 32'd4;
    localparam int CLK_HZ              = 32'd50_000_000;
    // 10 ms settle time, 300 ms to first repeat, 50 ms between repeats
    localparam int DEBOUNCE_CYCLES_DEF = CLK_HZ / 32'd100;
    localparam int REPEAT_DELAY_DEF    = (CLK_HZ / 32'd10) * 32'd3;
    localparam int REPEAT_PERIOD_DEF   = CLK_HZ / 32'd20;

    typedef logic [KEYS_W-1:0] keys_t;

endpackage

// File: rtl/key_debounce_channel.sv
// One key: 2-flop synchronizer, debounce counter, accepted state and pulses.
// Optional auto-repeat on held keys when KEY_CONDITIONER_REPEAT_EN is defined.
module key_debounce_channel
    import pong_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic key_n_i,
    output logic key_o,
    output logic press_o,
    output logic release_o
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("key_debounce_channel: DEBOUNCE_CYCLES must be at least 2");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("key_debounce_channel: REPEAT_DELAY and REPEAT_PERIOD must be positive");
    end

    logic             sync1_r;
    logic             sync2_r;
    logic             st_r;
    logic             press_r;
    logic             release_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             accept_s;
    logic             repeat_pulse_s;

    // Synchronize the inverted (active-high) pin into the clock domain
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= ~key_n_i;
            sync2_r <= sync1_r;
        end
    end

    // Any agreement restarts the count; accept after DEBOUNCE_CYCLES disagreeing samples
    always_comb begin
        accept_s  = 1'b0;
        cnt_nxt_s = '0;
        if (sync2_r == st_r) begin
            cnt_nxt_s = '0;
        end else if (cnt_r == CNT_MAX) begin
            accept_s  = 1'b1;
            cnt_nxt_s = '0;
        end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1'b1);
        end
    end

    // Counter, accepted level and edge pulses, all registered together
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_r     <= '0;
            st_r      <= 1'b0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
        end else begin
            cnt_r     <= cnt_nxt_s;
            if (accept_s) begin
                st_r <= sync2_r;
            end else begin
                st_r <= st_r;
            end
            press_r   <= (accept_s & sync2_r) | repeat_pulse_s;
            release_r <= accept_s & ~sync2_r;
        end
    end

`ifdef KEY_CONDITIONER_REPEAT_EN
    localparam int               REP_W      = $clog2(REPEAT_DELAY + 32'd1);
    localparam logic [REP_W-1:0] REP_FIRE   = REP_W'(REPEAT_DELAY - 32'd1);
    // After the first repeat, restart part-way so later repeats are REPEAT_PERIOD apart
    localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REPEAT_DELAY - REPEAT_PERIOD);

    if (REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_period
        $error("key_debounce_channel: REPEAT_PERIOD must not exceed REPEAT_DELAY");
    end

    logic [REP_W-1:0] rep_cnt_r;

    assign repeat_pulse_s = st_r & ~accept_s & (rep_cnt_r == REP_FIRE);

    // Repeat timer runs only while the accepted level is held; cleared on any acceptance
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rep_cnt_r <= '0;
        end else if (accept_s || !st_r) begin
            rep_cnt_r <= '0;
        end else if (rep_cnt_r == REP_FIRE) begin
            rep_cnt_r <= REP_RELOAD;
        end else begin
            rep_cnt_r <= rep_cnt_r + REP_W'(1'b1);
        end
    end
`else
    assign repeat_pulse_s = 1'b0;
`endif

    assign key_o     = st_r;
    assign press_o   = press_r;
    assign release_o = release_r;

endmodule

// File: rtl/key_conditioner.sv
// Conditions the raw active-low key pins into clean levels and press/release
// pulses, one independent channel per key. Auto-repeat: KEY_CONDITIONER_REPEAT_EN.
module key_conditioner
    import pong_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic  clk_i,
    input  logic  rst_n_i,
    input  keys_t keys_n_i,
    output keys_t keys_o,
    output keys_t keys_press_o,
    output keys_t keys_release_o
);

    for (genvar k = 0; k < KEYS_W; k++) begin : g_key
        key_debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_channel (
            .clk_i    (clk_i),
            .rst_n_i  (rst_n_i),
            .key_n_i  (keys_n_i[k]),
            .key_o    (keys_o[k]),
            .press_o  (keys_press_o[k]),
            .release_o(keys_release_o[k])
        );
    end

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Input conditioning stage between the board's push-buttons and the game logic. It takes the raw, active-low, asynchronous key pins, synchronizes and debounces each key independently, and presents clean active-high levels plus one-cycle press/release pulses to `game_top`. This replaces the bare inversion at the board boundary, so paddle control sees neither metastable nor bouncing inputs.

## Interface
- `KEYS_W`, default 4: number of keys, from the shared package.
- `DEBOUNCE_CYCLES`, default 500_000: consecutive stable cycles required to accept a new key level (10 ms at 50 MHz); must be ≥ 2.
- `REPEAT_DELAY`, default 15_000_000: cycles from accepted press to first auto-repeat pulse; only used with repeat compiled in.
- `REPEAT_PERIOD`, default 2_500_000: cycles between subsequent auto-repeat pulses; only used with repeat compiled in.
- `clk_i` input 1: system clock.
- `rst_n_i` input 1: asynchronous active-low reset.
- `keys_n_i` input KEYS_W: raw key pins, active-low, asynchronous to `clk_i`.
- `keys_o` output KEYS_W: debounced key level, active-high.
- `keys_press_o` output KEYS_W: one-cycle pulse per accepted press (and per auto-repeat when enabled).
- `keys_release_o` output KEYS_W: one-cycle pulse per accepted release.

## Operation
- Per key, fully independent: a 2-flop synchronizer on the inverted pin gives sample `s`, then a debounce counter `cnt` and accepted state `st`.
- Each cycle: if `s == st`, set `cnt` to 0. If `s != st` and `cnt == DEBOUNCE_CYCLES-1`, set `st` to `s` and `cnt` to 0. Otherwise increment `cnt`.
- Any single cycle of agreement restarts the count, so a glitch shorter than `DEBOUNCE_CYCLES` cycles never changes `st`.
- `keys_o = st`, driven directly from the register.
- `keys_press_o` pulses (registered) in the cycle `st` goes 0→1. `keys_release_o` pulses in the cycle `st` goes 1→0. Both are never high together for the same key.
- Counter width is `$clog2(DEBOUNCE_CYCLES)`. The counter saturates by construction and never wraps.
- Simultaneous events on different keys are handled in parallel with no priority.
- Reset, asynchronous and including mid-count: synchronizer flops go to 0 (released), and `cnt`, `st`, and all pulse and repeat state clear. All outputs are 0 while `rst_n_i` is low and in the first cycle after it deasserts.
- A key held through reset release is accepted as a new press `DEBOUNCE_CYCLES+2` edges later.

## Timing
- Latency from raw pin edge to `keys_o` change is `DEBOUNCE_CYCLES+2` rising edges: 2 for the synchronizer, `DEBOUNCE_CYCLES` for the count. A level stable for less than `DEBOUNCE_CYCLES` sampled cycles is ignored.
- The press/release pulse is coincident with the `keys_o` transition and exactly 1 cycle wide.
- The minimum spacing between accepted transitions of one key is `DEBOUNCE_CYCLES` cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- Macro: `KEY_CONDITIONER_REPEAT_EN`.
- When defined:
  - While `st` stays 1, a per-key repeat counter runs.
  - An extra `keys_press_o` pulse fires `REPEAT_DELAY` cycles after the accepted press, then every `REPEAT_PERIOD` cycles.
  - An accepted release or a reset clears the repeat counter immediately, and no pulse fires in the release cycle.
- When undefined: the repeat logic and the `REPEAT_*` parameters have no effect. Exactly one press pulse is generated per accepted press.

## Structure
- Shared package `pong_pkg`: `KEYS_W`, the default debounce and repeat cycle constants derived from the 50 MHz clock, and a `keys_t` typedef (`logic [KEYS_W-1:0]`).
- One sub-module, `key_debounce_channel`, handles a single key (synchronizer, counter, state, pulses, optional repeat). It is instantiated `KEYS_W` times in a generate loop.
- The top level contains only the generate loop and output bit assembly.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`, `REPEAT_DELAY=10`, `REPEAT_PERIOD=5`.
- **Clean press:** drive `keys_n_i[0]` 1→0 and hold → `keys_o[0]` rises 6 edges later, with `keys_press_o[0]` high for exactly that one cycle. Other bits stay 0.
- **Bounce rejection:** toggle `keys_n_i[1]` low for 3 cycles, high for 1, low for 3, then high → `keys_o[1]`, `keys_press_o[1]` and `keys_release_o[1]` stay 0 throughout.
- **Release:** from held, drive the pin high → `keys_o` falls 6 edges later, with `keys_release_o` pulsing for 1 cycle and no press pulse.
- **Simultaneous keys:** assert all 4 pins low on the same edge → all `keys_o` bits rise on the same cycle, with `keys_press_o == 4'hF` for one cycle.
- **Reset mid-operation:** pull `rst_n_i` low at count 2 of a press → all outputs go 0 asynchronously. After release with the key still held, the press is accepted 6 edges later.
- **Repeat enabled** (`KEY_CONDITIONER_REPEAT_EN` defined): hold the key for 40 cycles → press pulses at acceptance, at +10, +15, +20, +25, +30, +35. After release, no further press pulses.
